// File: rtl/seq_detect_pkg.sv
// Shared constants for the seq_detect family: match-mode encodings, the default
// pattern and the legal pattern-width range.
package seq_detect_pkg;

    localparam logic MODE_OVERLAP    = 1'b1;
    localparam logic MODE_NONOVERLAP = 1'b0;

    localparam int unsigned DEFAULT_PAT_W = 4;
    localparam logic [DEFAULT_PAT_W-1:0] DEFAULT_PAT = 4'b1011;

    localparam int unsigned PAT_W_MIN = 2;
    localparam int unsigned PAT_W_MAX = 32;

    function automatic bit pat_w_ok(input int unsigned w);
        return (w >= PAT_W_MIN) && (w <= PAT_W_MAX);
    endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter with synchronous clear; a clear that coincides with an
// increment leaves the count at 1 so that event is not dropped.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = inc ? W'(1) : '0;
        end else if (inc && (q_q != MAX_VAL)) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with a runtime-loadable pattern, overlapping or
// non-overlapping match mode, input qualification and a saturating match count.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int unsigned      PAT_W    = DEFAULT_PAT_W,
    parameter logic [PAT_W-1:0] PAT_INIT = PAT_W'(DEFAULT_PAT),
    parameter int unsigned      CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             flag,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int unsigned FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
    // History holds PAT_W-1 bits, so the incoming bit can complete a window once
    // that many have been accepted.
    localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PAT_W - 1);

    if (!pat_w_ok(PAT_W)) begin : g_bad_pat_w
        $error("seq_detect_param: PAT_W=%0d outside %0d..%0d", PAT_W, PAT_W_MIN, PAT_W_MAX);
    end

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("seq_detect_param: CNT_W must be at least 1");
    end

    logic [PAT_W-2:0]  sh_q, sh_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic              flag_q, flag_d;
    logic [PAT_W-1:0]  window;
    logic              match;

    always_comb begin
        window = {sh_q, din};
        match  = 1'b0;
        sh_d   = sh_q;
        fill_d = fill_q;
        pat_d  = pat_q;

        if (pat_load) begin
            pat_d  = pat_in;
            fill_d = '0;
        end else if (din_valid) begin
            sh_d  = window[PAT_W-2:0];
            match = (fill_q >= FILL_ARM) && (window == pat_q);
            if (match) begin
                fill_d = (overlap == MODE_OVERLAP) ? FILL_MAX : '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end

        flag_d = match;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q   <= '0;
            fill_q <= '0;
            pat_q  <= PAT_INIT;
            flag_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            flag_q <= flag_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk(clk),
        .rst(rst),
        .inc(match),
        .clr(cnt_clr),
        .q  (match_cnt)
    );

    assign flag = flag_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: two instances (CNT_W=8 and CNT_W=2)
// share stimulus; the driver queues expected flag/count per edge, a monitor checks.
module tb_seq_detect_param;

    logic       clk;
    logic       rst;
    logic       din;
    logic       din_valid;
    logic       overlap;
    logic       pat_load;
    logic [3:0] pat_in;
    logic       cnt_clr;
    logic       flag_a, flag_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    typedef struct packed {
        logic       flag;
        logic [7:0] cnt_a;
        logic [1:0] cnt_b;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_cnt_a;
    logic [1:0] exp_cnt_b;
    int         checks;
    int         failures;
    string      cur_test;

    seq_detect_param #(
        .PAT_W   (4),
        .PAT_INIT(4'b1011),
        .CNT_W   (8)
    ) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .din_valid(din_valid),
        .overlap  (overlap),
        .pat_load (pat_load),
        .pat_in   (pat_in),
        .cnt_clr  (cnt_clr),
        .flag     (flag_a),
        .match_cnt(cnt_a)
    );

    seq_detect_param #(
        .PAT_W   (4),
        .PAT_INIT(4'b1011),
        .CNT_W   (2)
    ) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .din_valid(din_valid),
        .overlap  (overlap),
        .pat_load (pat_load),
        .pat_in   (pat_in),
        .cnt_clr  (cnt_clr),
        .flag     (flag_b),
        .match_cnt(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s/%s: got %0d expected %0d at %0t", cur_test, name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin : pop
            exp_t e;
            e = exp_q.pop_front();
            chk("flag_a", int'(flag_a), int'(e.flag));
            chk("flag_b", int'(flag_b), int'(e.flag));
            chk("cnt_a", int'(cnt_a), int'(e.cnt_a));
            chk("cnt_b", int'(cnt_b), int'(e.cnt_b));
        end
    end

    // Drive one edge and queue what both instances must show after it.
    task automatic step(input logic d, input logic dv, input logic ov, input logic pl,
                        input logic [3:0] pi, input logic cc, input logic ef);
        exp_t e;
        @(negedge clk);
        din       = d;
        din_valid = dv;
        overlap   = ov;
        pat_load  = pl;
        pat_in    = pi;
        cnt_clr   = cc;
        @(posedge clk);
        if (cc) begin
            exp_cnt_a = ef ? 8'd1 : 8'd0;
            exp_cnt_b = ef ? 2'd1 : 2'd0;
        end else if (ef) begin
            if (exp_cnt_a != 8'hff) exp_cnt_a = exp_cnt_a + 8'd1;
            if (exp_cnt_b != 2'd3) exp_cnt_b = exp_cnt_b + 2'd1;
        end
        e.flag  = ef;
        e.cnt_a = exp_cnt_a;
        e.cnt_b = exp_cnt_b;
        exp_q.push_back(e);
    endtask

    // s: '0'/'1' accepted bits, 'a'/'b' unqualified cycles with din=0/1.
    // f: expected flag after each edge.
    task automatic run(input string s, input string f, input logic ov,
                       input logic cc_last = 1'b0);
        byte  c;
        logic dv;
        logic d;
        for (int i = 0; i < s.len(); i++) begin
            c  = s[i];
            dv = (c == "0") || (c == "1");
            d  = (c == "1") || (c == "b");
            step(d, dv, ov, 1'b0, 4'b0000, cc_last && (i == s.len() - 1), f[i] == "1");
        end
    endtask

    // Asynchronous reset entirely within the low clock phase.
    task automatic do_reset();
        @(negedge clk);
        din       = 1'b0;
        din_valid = 1'b0;
        pat_load  = 1'b0;
        pat_in    = 4'b0000;
        cnt_clr   = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_flag_a", int'(flag_a), 0);
        chk("rst_flag_b", int'(flag_b), 0);
        chk("rst_cnt_a", int'(cnt_a), 0);
        chk("rst_cnt_b", int'(cnt_b), 0);
        #1 rst = 1'b0;
        exp_cnt_a = 8'd0;
        exp_cnt_b = 2'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        exp_cnt_a = 8'd0;
        exp_cnt_b = 2'd0;
        rst       = 1'b1;
        din       = 1'b0;
        din_valid = 1'b0;
        overlap   = 1'b1;
        pat_load  = 1'b0;
        pat_in    = 4'b0000;
        cnt_clr   = 1'b0;

        cur_test = "reset";
        do_reset();

        cur_test = "overlap";
        run("1011011", "0001001", 1'b1);

        // Flag is high going into this reset: it must drop asynchronously.
        cur_test = "nonoverlap";
        do_reset();
        run("1011011", "0001000", 1'b0);

        cur_test = "valid_gaps";
        do_reset();
        run("1bab0bba1abb1aa", "000000000000100", 1'b1);

        // Load edge carries a 1 that would complete 1011 under the old pattern.
        cur_test = "pat_load";
        do_reset();
        run("101", "000", 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0);
        run("0110", "0001", 1'b1);

        cur_test = "reset_mid";
        do_reset();
        run("101", "000", 1'b1);
        do_reset();
        run("1", "0", 1'b1);

        cur_test = "saturate";
        do_reset();
        run("1011011011011", "0001001001001", 1'b1);

        cur_test = "clr_with_match";
        run("011", "001", 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
